// File: rtl/sram_wb_bist_master_if.sv
// Wishbone classic bus between the BIST initiator and the SRAM slave mux.
//   wbm_cyc_o/stb_o/we_o  : cycle, strobe, write enable (initiator -> slave)
//   wbm_sel_o             : byte selects
//   wbm_adr_o/dat_o       : byte address and write data
//   wbm_dat_i/ack_i       : read data and acknowledge (slave -> initiator)
interface sram_wb_bist_master_if;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    modport master (
        output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        input  wbm_dat_i, wbm_ack_i
    );

    modport slave (
        input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
        output wbm_dat_i, wbm_ack_i
    );
endinterface

// File: rtl/sram_wb_bist_master.sv
// Wishbone classic BIST initiator for the 1024x32 SRAM slave.
// A start pulse runs a write pass of the selected pattern over WORDS words,
// then a read pass comparing every word, and reports the result.
//   wb_clk_i, wb_rst_i : clock, synchronous active-high reset
//   start, pattern_sel : begin a test (ignored while busy), pattern choice
//   busy, done, pass   : test status; pass valid while done
//   timeout            : a request went unacknowledged for TIMEOUT cycles
//   fail_idx/fail_data : index and read data of the first mismatch
//   err_count          : saturating mismatch count
//   wbm                : Wishbone initiator port
module sram_wb_bist_master #(
    parameter logic [31:0] BASE_ADR = 32'h3000_0000,
    parameter int unsigned WORDS    = 1024,
    parameter int unsigned TIMEOUT  = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        start,
    input  logic [1:0]  pattern_sel,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [9:0]  fail_idx,
    output logic [31:0] fail_data,
    output logic [15:0] err_count,
    sram_wb_bist_master_if.master wbm
);

    localparam int unsigned IDX_W = 10;
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_GAP,
        RD_REQ,
        RD_GAP,
        FINISH
    } state_t;

    state_t            state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [1:0]        pat_q;
    logic [TO_W-1:0]   to_cnt_q;

    logic              busy_q;
    logic              done_q;
    logic              pass_q;
    logic              timeout_q;
    logic [IDX_W-1:0]  fail_idx_q;
    logic [31:0]       fail_data_q;
    logic [15:0]       err_count_q;

    logic              cyc_q;
    logic              stb_q;
    logic              we_q;
    logic [3:0]        sel_q;
    logic [31:0]       adr_q;
    logic [31:0]       dat_q;

    logic              last_c;
    logic [IDX_W-1:0]  nxt_idx_c;
    logic [31:0]       exp_c;
    logic              mismatch_c;
    logic              to_hit_c;

    // Expected word for a given index and pattern.
    function automatic logic [31:0] pat_of(input logic [IDX_W-1:0] i, input logic [1:0] p);
        logic [31:0] r;
        case (p)
            2'd0:    r = 32'(i);
            2'd1:    r = i[0] ? 32'hAAAA_AAAA : 32'h5555_5555;
            2'd2:    r = 32'hFFFF_FFFF;
            default: r = ~32'(i);
        endcase
        return r;
    endfunction

    // Byte address of a word index.
    function automatic logic [31:0] adr_of(input logic [IDX_W-1:0] i);
        return BASE_ADR + {20'd0, i, 2'b00};
    endfunction

    // Index stepping and read compare against the current request.
    always_comb begin
        last_c     = (idx_q == IDX_W'(WORDS - 1));
        nxt_idx_c  = last_c ? '0 : idx_q + IDX_W'(1);
        exp_c      = pat_of(idx_q, pat_q);
        mismatch_c = (wbm.wbm_dat_i != exp_c);
        to_hit_c   = (to_cnt_q == TO_W'(TIMEOUT - 1));
    end

    // Test sequencer: state, bus request and status registers.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            pat_q       <= '0;
            to_cnt_q    <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            timeout_q   <= 1'b0;
            fail_idx_q  <= '0;
            fail_data_q <= '0;
            err_count_q <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            sel_q       <= '0;
            adr_q       <= '0;
            dat_q       <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q     <= WR_REQ;
                        busy_q      <= 1'b1;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        timeout_q   <= 1'b0;
                        err_count_q <= '0;
                        fail_idx_q  <= '0;
                        fail_data_q <= '0;
                        idx_q       <= '0;
                        pat_q       <= pattern_sel;
                        to_cnt_q    <= '0;
                        cyc_q       <= 1'b1;
                        stb_q       <= 1'b1;
                        we_q        <= 1'b1;
                        sel_q       <= 4'hF;
                        adr_q       <= adr_of('0);
                        dat_q       <= pat_of('0, pattern_sel);
                    end
                end

                WR_REQ, RD_REQ: begin
                    if (wbm.wbm_ack_i) begin
                        cyc_q <= 1'b0;
                        stb_q <= 1'b0;
                        we_q  <= 1'b0;
                        sel_q <= '0;
                        if (state_q == WR_REQ) begin
                            state_q <= WR_GAP;
                        end else begin
                            state_q <= RD_GAP;
                            if (mismatch_c) begin
                                if (err_count_q != 16'hFFFF) begin
                                    err_count_q <= err_count_q + 16'd1;
                                end
                                // Only the first mismatch of a test is captured.
                                if (err_count_q == 16'd0) begin
                                    fail_idx_q  <= idx_q;
                                    fail_data_q <= wbm.wbm_dat_i;
                                end
                            end
                        end
                    end else if (to_hit_c) begin
                        // Abandon the test; the stalled slave is left alone.
                        cyc_q     <= 1'b0;
                        stb_q     <= 1'b0;
                        we_q      <= 1'b0;
                        sel_q     <= '0;
                        timeout_q <= 1'b1;
                        state_q   <= FINISH;
                    end else begin
                        to_cnt_q <= to_cnt_q + TO_W'(1);
                    end
                end

                WR_GAP: begin
                    idx_q    <= nxt_idx_c;
                    to_cnt_q <= '0;
                    cyc_q    <= 1'b1;
                    stb_q    <= 1'b1;
                    sel_q    <= 4'hF;
                    adr_q    <= adr_of(nxt_idx_c);
                    if (last_c) begin
                        we_q    <= 1'b0;
                        state_q <= RD_REQ;
                    end else begin
                        we_q    <= 1'b1;
                        dat_q   <= pat_of(nxt_idx_c, pat_q);
                        state_q <= WR_REQ;
                    end
                end

                RD_GAP: begin
                    idx_q    <= nxt_idx_c;
                    to_cnt_q <= '0;
                    if (last_c) begin
                        state_q <= FINISH;
                    end else begin
                        cyc_q   <= 1'b1;
                        stb_q   <= 1'b1;
                        we_q    <= 1'b0;
                        sel_q   <= 4'hF;
                        adr_q   <= adr_of(nxt_idx_c);
                        state_q <= RD_REQ;
                    end
                end

                FINISH: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    pass_q  <= (err_count_q == 16'd0) && !timeout_q;
                    state_q <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign timeout       = timeout_q;
    assign fail_idx      = fail_idx_q;
    assign fail_data     = fail_data_q;
    assign err_count     = err_count_q;
    assign wbm.wbm_cyc_o = cyc_q;
    assign wbm.wbm_stb_o = stb_q;
    assign wbm.wbm_we_o  = we_q;
    assign wbm.wbm_sel_o = sel_q;
    assign wbm.wbm_adr_o = adr_q;
    assign wbm.wbm_dat_o = dat_q;

endmodule

// File: tb/tb_sram_wb_bist_master.sv
// Bench for sram_wb_bist_master: SRAM slave model with configurable ack
// latency, stall and read faults, a bus monitor, a table of full-test
// vectors and hand-written timeout / reset / random-latency sequences.
module tb_sram_wb_bist_master;

    localparam logic [31:0] BASE = 32'h3000_0000;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  pattern_sel = 2'd0;
    logic        busy, done, pass, timeout;
    logic [9:0]  fail_idx;
    logic [31:0] fail_data;
    logic [15:0] err_count;

    sram_wb_bist_master_if bus ();

    sram_wb_bist_master dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .start       (start),
        .pattern_sel (pattern_sel),
        .busy        (busy),
        .done        (done),
        .pass        (pass),
        .timeout     (timeout),
        .fail_idx    (fail_idx),
        .fail_data   (fail_data),
        .err_count   (err_count),
        .wbm         (bus)
    );

    always #5 clk = ~clk;

    // Slave controls set by the stimulus.
    logic        rand_en = 1'b0;
    logic        spur_en = 1'b0;
    logic        stall_en = 1'b0;
    logic        stuck_en = 1'b0;
    logic        zero_en = 1'b0;
    logic        clr = 1'b0;
    logic [1:0]  tb_pat = 2'd0;

    logic [31:0] mem [1024];
    int          lat_cnt = 0;
    int          cur_lat = 1;
    int          wr_n = 0;
    int          rd_n = 0;
    int          bus_err = 0;
    logic        pend = 1'b0;
    logic [31:0] padr = '0;
    logic [31:0] pdat = '0;
    logic        pwe = 1'b0;

    int n_tests = 0;
    int n_fail = 0;

    function automatic logic [31:0] pat_model(input int i, input logic [1:0] p);
        logic [31:0] iv;
        iv = 32'(i);
        if (p == 2'd0) return iv;
        if (p == 2'd1) return (i % 2 == 1) ? 32'hAAAA_AAAA : 32'h5555_5555;
        if (p == 2'd2) return 32'hFFFF_FFFF;
        return ~iv;
    endfunction

    logic        req_c, stall_c, ack_c;
    logic [9:0]  ridx_c;
    logic [31:0] rdat_c;
    logic        sel_bad, hold_bad, wr_bad, rd_bad;

    always_comb begin
        req_c   = bus.wbm_cyc_o && bus.wbm_stb_o;
        ridx_c  = bus.wbm_adr_o[11:2];
        stall_c = stall_en && bus.wbm_we_o && (bus.wbm_adr_o == BASE + 32'd12);
        ack_c   = req_c ? (!stall_c && (lat_cnt >= cur_lat - 1)) : spur_en;
        rdat_c  = mem[ridx_c];
        if (zero_en) rdat_c = 32'd0;
        else if (stuck_en && ridx_c == 10'd5) rdat_c = rdat_c & ~32'h0000_0080;
        sel_bad  = req_c && (bus.wbm_sel_o != 4'hF);
        hold_bad = req_c && pend && (bus.wbm_adr_o != padr || bus.wbm_dat_o != pdat || bus.wbm_we_o != pwe);
        wr_bad   = req_c && ack_c && bus.wbm_we_o &&
                   (bus.wbm_adr_o != BASE + 32'(wr_n * 4) || bus.wbm_dat_o != pat_model(wr_n, tb_pat));
        rd_bad   = req_c && ack_c && !bus.wbm_we_o && (bus.wbm_adr_o != BASE + 32'(rd_n * 4));
    end

    assign bus.wbm_ack_i = ack_c;
    assign bus.wbm_dat_i = rdat_c;

    // Slave storage, latency tracking and bus monitor.
    always @(posedge clk) begin
        if (req_c && ack_c && bus.wbm_we_o) mem[ridx_c] <= bus.wbm_dat_o;
        if (!req_c || ack_c) lat_cnt <= 0;
        else lat_cnt <= lat_cnt + 1;
        if (req_c && ack_c) cur_lat <= rand_en ? int'($urandom_range(1, 7)) : 1;
        if (clr) begin
            wr_n <= 0;
            rd_n <= 0;
            bus_err <= 0;
            pend <= 1'b0;
        end else begin
            bus_err <= bus_err + int'(sel_bad) + int'(hold_bad) + int'(wr_bad) + int'(rd_bad);
            if (req_c && ack_c && bus.wbm_we_o) wr_n <= wr_n + 1;
            if (req_c && ack_c && !bus.wbm_we_o) rd_n <= rd_n + 1;
            pend <= req_c && !ack_c;
            padr <= bus.wbm_adr_o;
            pdat <= bus.wbm_dat_o;
            pwe  <= bus.wbm_we_o;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Start a test, optionally pulse start again at a given cycle, wait for done.
    task automatic run(input logic [1:0] pat, input int budget, input int pulse_at,
                       input logic [1:0] pulse_pat, output int cycles);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tb_pat = pat;
        pattern_sel = pat;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cycles = 0;
        chk("busy_after_start", 64'(busy), 64'd1);
        while (!done && cycles < budget) begin
            if (cycles == pulse_at) begin
                pattern_sel = pulse_pat;
                start = 1'b1;
            end
            @(negedge clk);
            cycles++;
            start = 1'b0;
        end
        if (!done) chk("done_within_budget", 64'(done), 64'd1);
    endtask

    typedef struct {
        logic [1:0]  pat;
        int          fault;      // 0 none, 1 word 5 bit 7 stuck low, 2 reads return 0
        int          pulse_at;   // cycle of an extra start pulse, -1 for none
        logic        exp_pass;
        logic [15:0] exp_err;
        logic [9:0]  exp_fidx;
        logic [31:0] exp_fdata;
    } vec_t;

    vec_t vecs[5];
    int   cyc;

    initial begin
        vecs[0] = '{2'd0, 0, -1,   1'b1, 16'd0,    10'd0, 32'h0000_0000};
        vecs[1] = '{2'd1, 1, -1,   1'b0, 16'd1,    10'd5, 32'hAAAA_AA2A};
        vecs[2] = '{2'd3, 2, -1,   1'b0, 16'd1024, 10'd0, 32'h0000_0000};
        vecs[3] = '{2'd2, 0, 4096, 1'b1, 16'd0,    10'd0, 32'h0000_0000};
        vecs[4] = '{2'd1, 0, -1,   1'b1, 16'd0,    10'd0, 32'h0000_0000};

        // Reset state.
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_status", {busy, done, pass, timeout}, 64'd0);
        chk("rst_fail_idx", 64'(fail_idx), 64'd0);
        chk("rst_fail_data", 64'(fail_data), 64'd0);
        chk("rst_err_count", 64'(err_count), 64'd0);
        chk("rst_bus_ctl", {bus.wbm_cyc_o, bus.wbm_stb_o, bus.wbm_we_o, bus.wbm_sel_o}, 64'd0);
        chk("rst_bus_adr_dat", {bus.wbm_adr_o, bus.wbm_dat_o}, 64'd0);

        // Full tests from the vector table.
        for (int v = 0; v < 5; v++) begin
            stuck_en = (vecs[v].fault == 1);
            zero_en  = (vecs[v].fault == 2);
            run(vecs[v].pat, 6000, vecs[v].pulse_at, 2'd0, cyc);
            chk($sformatf("v%0d_cycles", v), 64'(cyc), 64'd4097);
            chk($sformatf("v%0d_done", v), 64'(done), 64'd1);
            chk($sformatf("v%0d_pass", v), 64'(pass), 64'(vecs[v].exp_pass));
            chk($sformatf("v%0d_err_count", v), 64'(err_count), 64'(vecs[v].exp_err));
            chk($sformatf("v%0d_fail_idx", v), 64'(fail_idx), 64'(vecs[v].exp_fidx));
            chk($sformatf("v%0d_fail_data", v), 64'(fail_data), 64'(vecs[v].exp_fdata));
            chk($sformatf("v%0d_timeout", v), 64'(timeout), 64'd0);
            chk($sformatf("v%0d_bus_err", v), 64'(bus_err), 64'd0);
            chk($sformatf("v%0d_writes", v), 64'(wr_n), 64'd1024);
            chk($sformatf("v%0d_reads", v), 64'(rd_n), 64'd1024);
            repeat (3) @(negedge clk);
            chk($sformatf("v%0d_idle_after", v), {busy, done, bus.wbm_cyc_o}, 64'b010);
        end
        stuck_en = 1'b0;
        zero_en  = 1'b0;

        // Write of word 3 never acknowledged: abort after 255 stalled cycles.
        stall_en = 1'b1;
        run(2'd0, 1000, -1, 2'd0, cyc);
        chk("to_cycles", 64'(cyc), 64'd262);
        chk("to_status", {done, pass, timeout, busy}, 64'b1010);
        chk("to_bus_idle", {bus.wbm_cyc_o, bus.wbm_stb_o}, 64'd0);
        chk("to_writes", 64'(wr_n), 64'd3);
        chk("to_reads", 64'(rd_n), 64'd0);
        stall_en = 1'b0;

        // Reset pulsed during the read of word 100.
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        tb_pat = 2'd0;
        pattern_sel = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (!(req_c && !bus.wbm_we_o && bus.wbm_adr_o == BASE + 32'd400) && cyc < 5000) begin
            @(negedge clk);
            cyc++;
        end
        chk("rst_mid_reached_word100", 64'(bus.wbm_adr_o), 64'(BASE + 32'd400));
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_bus", {bus.wbm_cyc_o, bus.wbm_stb_o, busy}, 64'd0);
        chk("rst_mid_status", {done, pass, timeout, err_count, fail_idx, fail_data}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        run(2'd0, 6000, -1, 2'd0, cyc);
        chk("rst_mid_rerun_cycles", 64'(cyc), 64'd4097);
        chk("rst_mid_rerun_pass", {done, pass, err_count}, {1'b1, 1'b1, 16'd0});

        // Random ack latency, acks during gaps, and a start pulse while busy.
        rand_en = 1'b1;
        spur_en = 1'b1;
        run(2'd1, 40000, 500, 2'd3, cyc);
        chk("rand_pass", {done, pass, timeout}, 64'b110);
        chk("rand_err_count", 64'(err_count), 64'd0);
        chk("rand_bus_err", 64'(bus_err), 64'd0);
        chk("rand_writes", 64'(wr_n), 64'd1024);
        chk("rand_reads", 64'(rd_n), 64'd1024);
        chk("rand_min_cycles", 64'(cyc > 4097), 64'd1);
        spur_en = 1'b0;
        repeat (3) @(negedge clk);
        chk("rand_no_restart", {busy, done}, 64'b01);
        rand_en = 1'b0;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
